// File: rtl/train_seq_ctrl.sv
// train_seq_ctrl: epoch sequencer (CLEAR/FWD/BWD/UPDATE) for the perceptron datapath; optional phase watchdog under TRAIN_SEQ_WDOG_EN
// ports: clk_i/rst_i (sync, active-low), en_i freeze, init_i start edge, abort_i to IDLE, epochs_i target,
//        zero_end_check_i/f_end_i/b_end_i phase strobes; zero_loss_o/zero_final_o/f_pass_o/b_pass_o/zero_weight_update_o
//        phase controls, epoch_o completed epochs, busy_o/done_o/err_o status, state_o debug state (0..6)
module train_seq_ctrl #(
  parameter int EPOCH_W = 8,
  parameter int WDOG_W = 6,
  parameter int TIMEOUT = 63
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               en_i,
  input  logic               init_i,
  input  logic               abort_i,
  input  logic [EPOCH_W-1:0] epochs_i,
  input  logic               zero_end_check_i,
  input  logic               f_end_i,
  input  logic               b_end_i,
  output logic               zero_loss_o,
  output logic               zero_final_o,
  output logic               f_pass_o,
  output logic               b_pass_o,
  output logic               zero_weight_update_o,
  output logic [EPOCH_W-1:0] epoch_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o,
  output logic [2:0]         state_o
);
  typedef enum logic [2:0] {IDLE, CLEAR, FWD, BWD, UPDATE, DONE, ERR} state_t;
  state_t state_q, state_d;
  logic init_q, init_d, start, waiting, strobe, tmo;
  logic [EPOCH_W-1:0] epoch_q, epoch_d, target_q, target_d, epoch_inc;
  if (TIMEOUT > (1 << WDOG_W) - 1) begin : g_bad_timeout
    $error("TIMEOUT does not fit in WDOG_W bits");
  end
  assign start = init_i & ~init_q;
  assign epoch_inc = epoch_q + 1'b1;
  assign waiting = state_q inside {CLEAR, FWD, BWD};
  assign strobe = (state_q == CLEAR & zero_end_check_i) | (state_q == FWD & f_end_i) | (state_q == BWD & b_end_i);
`ifdef TRAIN_SEQ_WDOG_EN
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  assign tmo = wdog_q == WDOG_W'(TIMEOUT);
  always_comb begin
    wdog_d = abort_i ? '0 : ~en_i ? wdog_q : (state_d != state_q || !waiting) ? '0 : wdog_q + 1'b1;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_i) wdog_q <= '0;
    else wdog_q <= wdog_d;
  end
  assign err_o = state_q == ERR;
`else
  assign tmo = 1'b0;
  assign err_o = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    epoch_d = epoch_q;
    target_d = target_q;
    init_d = en_i ? init_i : init_q;
    if (abort_i) state_d = IDLE;
    else if (en_i) begin
      if ((state_q == IDLE || state_q == DONE) && start) begin
        target_d = epochs_i;
        epoch_d = '0;
        state_d = epochs_i == '0 ? DONE : CLEAR;
      end else if (state_q == DONE && !init_i) state_d = IDLE;
      else if (state_q == UPDATE) begin
        epoch_d = epoch_inc;
        state_d = epoch_inc == target_q ? DONE : CLEAR;
      end else if (waiting && strobe) state_d = state_q == CLEAR ? FWD : state_q == FWD ? BWD : UPDATE;
      else if (waiting && tmo) state_d = ERR;
    end
  end
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      init_q <= init_i;
      epoch_q <= '0;
      target_q <= '0;
    end else begin
      state_q <= state_d;
      init_q <= init_d;
      epoch_q <= epoch_d;
      target_q <= target_d;
    end
  end
  assign zero_loss_o = state_q == CLEAR;
  assign zero_final_o = state_q == CLEAR;
  assign f_pass_o = state_q == FWD;
  assign b_pass_o = state_q == BWD;
  assign zero_weight_update_o = state_q == UPDATE;
  assign busy_o = state_q inside {CLEAR, FWD, BWD, UPDATE};
  assign done_o = state_q == DONE;
  assign epoch_o = epoch_q;
  assign state_o = state_q;
endmodule

// File: tb/tb_train_seq_ctrl.sv
// tb_train_seq_ctrl: randomized scoreboard bench for train_seq_ctrl
module tb_train_seq_ctrl;
  localparam int EW = 8;
  logic clk = 0, rst_i = 0, en_i = 1, init_i = 0, abort_i = 0;
  logic zero_end_check_i = 0, f_end_i = 0, b_end_i = 0;
  logic [EW-1:0] epochs_i = '0;
  logic zero_loss_o, zero_final_o, f_pass_o, b_pass_o, zero_weight_update_o, busy_o, done_o, err_o;
  logic [EW-1:0] epoch_o;
  logic [2:0] state_o;
  int ncyc = 0, nvec = 0, nerr = 0;
  int cc = 0, cz = 0, cf = 0, cb = 0, cbusy = 0, ka;
  logic pd = 0, pe = 0;
  logic [2:0] ps = 0;
  typedef struct {int k; int cyc; int ep; int c; int f; int b; int busy;} ev_t;
  ev_t q[$];
  ev_t em;
  train_seq_ctrl #(.EPOCH_W(EW), .WDOG_W(6), .TIMEOUT(63)) dut (
    .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .init_i(init_i), .abort_i(abort_i), .epochs_i(epochs_i),
    .zero_end_check_i(zero_end_check_i), .f_end_i(f_end_i), .b_end_i(b_end_i),
    .zero_loss_o(zero_loss_o), .zero_final_o(zero_final_o), .f_pass_o(f_pass_o), .b_pass_o(b_pass_o),
    .zero_weight_update_o(zero_weight_update_o), .epoch_o(epoch_o), .busy_o(busy_o), .done_o(done_o),
    .err_o(err_o), .state_o(state_o)
  );
  always #5 clk = ~clk;
  always @(posedge clk) ncyc <= ncyc + 1;
  function automatic void chk(string nm, int act, int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, ncyc);
    end
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  // k is the state the DUT shows at the event: 4 update, 5 done, 6 err, 0 return to idle
  task automatic push(input int k, input int cyc, input int ep, input int c, input int f, input int b);
    ev_t e;
    e.k = k; e.cyc = cyc; e.ep = ep; e.c = c; e.f = f; e.b = b;
    e.busy = c + f + b + (k == 4 ? 1 : 0);
    q.push_back(e);
  endtask
  task automatic noise_until(input int c, input int own);
    while (ncyc < c) begin
      zero_end_check_i = own != 0 ? 1'($urandom) : 1'b0;
      f_end_i = own != 1 ? 1'($urandom) : 1'b0;
      b_end_i = own != 2 ? 1'($urandom) : 1'b0;
      tick;
    end
    {zero_end_check_i, f_end_i, b_end_i} = '0;
  endtask
  task automatic strobe(input int c, input int own);
    noise_until(c, own);
    zero_end_check_i = own == 0;
    f_end_i = own == 1;
    b_end_i = own == 2;
    tick;
    {zero_end_check_i, f_end_i, b_end_i} = '0;
  endtask
  function automatic int dly(input int fixd);
    return fixd >= 0 ? fixd : int'($urandom_range(0, 3));
  endfunction
  // mode: 0 plain, 1 freeze in first FWD, 2 abort in last BWD, 3 hang first FWD
  task automatic run(input int n, input int mode, input int fixd);
    int t, fe, be, u, dc, df, db, ex;
    epochs_i = EW'(n);
    init_i = 1;
    t = ncyc + 1;
    tick;
    init_i = 0;
    epochs_i = EW'($urandom);
    for (int k = 1; k <= n; k++) begin
      dc = dly(fixd); df = dly(fixd); db = dly(fixd);
      fe = t + dc + 1;
      if (mode == 3) begin
`ifdef TRAIN_SEQ_WDOG_EN
        push(6, fe + 64, k - 1, dc + 1, 64, 0);
        strobe(t + dc, 0);
        noise_until(fe + 70, 1);
        push(0, fe + 71, k - 1, 0, 0, 0);
`else
        strobe(t + dc, 0);
        noise_until(fe + 1000, 1);
        chk("hang_state", state_o, 2);
        chk("hang_err", err_o, 0);
        push(0, fe + 1001, k - 1, dc + 1, 1001, 0);
`endif
        abort_i = 1;
        tick;
        abort_i = 0;
        tick;
        return;
      end
      ex = (mode == 1 && k == 1) ? 11 : 0;
      be = fe + df + 1 + ex;
      if (mode == 2 && k == n) begin
        push(0, be + db + 1, k - 1, dc + 1, df + 1, db + 1);
        strobe(t + dc, 0);
        strobe(fe + df, 1);
        noise_until(be + db, 2);
        abort_i = 1;
        tick;
        abort_i = 0;
        chk("abort_state", state_o, 0);
        chk("abort_bpass", b_pass_o, 0);
        chk("abort_epoch", epoch_o, k - 1);
        tick;
        return;
      end
      u = be + db + 1;
      push(4, u, k - 1, dc + 1, df + 1 + ex, db + 1);
      strobe(t + dc, 0);
      if (ex != 0) begin
        tick;
        en_i = 0;
        f_end_i = 1;
        repeat (10) tick;
        chk("freeze_state", state_o, 2);
        chk("freeze_epoch", epoch_o, k - 1);
        en_i = 1;
        f_end_i = 0;
      end
      strobe(be - 1, 1);
      strobe(u - 1, 2);
      t = u + 1;
    end
    push(5, t, n, 0, 0, 0);
    while (ncyc < t + 2) tick;
  endtask
  initial begin
    forever begin
      @(negedge clk);
      cc += int'(zero_loss_o); cz += int'(zero_final_o); cf += int'(f_pass_o);
      cb += int'(b_pass_o); cbusy += int'(busy_o);
      ka = zero_weight_update_o ? 4 : (done_o & ~pd) ? 5 : (err_o & ~pe) ? 6 :
           (state_o == 3'd0 && ps != 3'd0 && ps != 3'd5) ? 0 : -1;
      if (ka >= 0) begin
        if (q.size() == 0) begin
          nvec++;
          nerr++;
          $display("FAIL unexpected_event: kind %0d at cycle %0d, none expected", ka, ncyc);
        end else begin
          em = q.pop_front();
          chk("ev_kind", ka, em.k);
          chk("ev_cycle", ncyc, em.cyc);
          chk("ev_state", int'(state_o), em.k);
          chk("ev_epoch", int'(epoch_o), em.ep);
          chk("ev_err", int'(err_o), em.k == 6 ? 1 : 0);
          chk("ev_zero_loss_cycles", cc, em.c);
          chk("ev_zero_final_cycles", cz, em.c);
          chk("ev_fpass_cycles", cf, em.f);
          chk("ev_bpass_cycles", cb, em.b);
          chk("ev_busy_cycles", cbusy, em.busy);
        end
        cc = 0; cz = 0; cf = 0; cb = 0; cbusy = 0;
      end
      pd = done_o;
      pe = err_o;
      ps = state_o;
    end
  end
  initial begin
    #1000000;
    $display("FAIL timeout: bench did not finish, %0d expected events pending", q.size());
    $fatal(1);
  end
  initial begin
    rst_i = 0;
    init_i = 1;
    tick;
    tick;
    chk("rst_state", state_o, 0);
    chk("rst_outputs", int'({zero_loss_o, zero_final_o, f_pass_o, b_pass_o, zero_weight_update_o, busy_o, done_o, err_o}), 0);
    chk("rst_epoch", epoch_o, 0);
    rst_i = 1;
    repeat (4) tick;
    chk("no_start_after_rst", state_o, 0);
    chk("no_busy_after_rst", busy_o, 0);
    init_i = 0;
    tick;
    tick;
    run(3, 0, 1);
    run(0, 0, -1);
    run(3, 1, -1);
    run(2, 2, -1);
    run(1, 3, -1);
    run(1, 0, 63);
    repeat (6) run(int'($urandom_range(0, 5)), 0, -1);
    run(255, 0, 0);
    repeat (3) tick;
    chk("scoreboard_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
